alarm_tone_player: RTL and testbench

- Consumer end of the alarm `play` level. Raised by the alarm-compare block and held high until reset.
- While `play` is high and the alarm is not dismissed, loops an 8-note melody as a square wave on `speaker`.
- Supports dismiss (`stop`), optional snooze, and an auto-timeout.
- After dismiss or timeout it stays silent until `play` drops, so the latched `play` level cannot retrigger it.

---
 rtl/alarm_tone_player.sv | 252 +++++++++++++++++++++++++
 tb/tb_alarm_tone_player.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_player.sv
// alarm_tone_player: loops an 8-note melody on a square-wave speaker output
// while the latched alarm `play` level is high. The player stops on a dismiss
// pulse or after a ring timeout, then stays silent until `play` drops.
// Optional feature macro: ALARM_SNOOZE_EN (adds the SNOOZE state and its timer).
// `state_dbg` exposes the FSM state (IDLE=0, RING=1, GAP=2, HOLD=3, SNOOZE=4).
// There is no handshake: `play` is a level, and `stop` and `snooze` are
// single-cycle pulses.
module alarm_tone_player #(
  parameter int CLK_HZ     = 100000000,
  parameter int NOTE_MS    = 250,
  parameter int MAX_PLAY_S = 60,
  parameter int SNOOZE_S   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  input  logic       snooze,
  output logic       speaker,
  output logic       active,
  output logic [2:0] note_idx,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int NOTE_CYC = (CLK_HZ / 1000) * NOTE_MS;
  localparam int GAP_CYC  = NOTE_CYC / 8;
  localparam int RING_CYC = NOTE_CYC - GAP_CYC;
  localparam int SEC_CYC  = CLK_HZ;
  localparam int HP_MAX   = CLK_HZ / (2 * 523);

  localparam int SLOT_W = $clog2(RING_CYC + 1);
  localparam int TONE_W = $clog2(HP_MAX + 1);
  localparam int SEC_W  = $clog2(SEC_CYC + 1);
  localparam int TMO_W  = $clog2(MAX_PLAY_S + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RING = 3'd1,
    GAP  = 3'd2,
    HOLD = 3'd3
`ifdef ALARM_SNOOZE_EN
    ,
    SNOOZE = 3'd4
`endif
  } state_t;

  // Melody ROM: half-period in clock cycles per note; 0 marks the rest.
  function automatic logic [TONE_W-1:0] hp_of(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd6: hp_of = TONE_W'(CLK_HZ / (2 * 523));
      3'd1, 3'd5: hp_of = TONE_W'(CLK_HZ / (2 * 659));
      3'd2, 3'd4: hp_of = TONE_W'(CLK_HZ / (2 * 784));
      3'd3:       hp_of = TONE_W'(CLK_HZ / (2 * 1047));
      default:    hp_of = '0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic                speaker_q, speaker_d;
  logic                active_q, active_d;
  logic [2:0]          note_q, note_d;
  logic                done_q, done_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SEC_W-1:0]    cyc_q, cyc_d;
  logic [TMO_W-1:0]    sec_q, sec_d;
  logic [TONE_W-1:0]   hp_cur;
  logic                ring_timeout;

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_S + 1);
  logic [SEC_W-1:0]    snz_cyc_q, snz_cyc_d;
  logic [SNZ_W-1:0]    snz_sec_q, snz_sec_d;
  logic                snooze_over;
  assign snooze_over = (snz_cyc_q == SEC_W'(SEC_CYC - 1)) &&
                       (snz_sec_q == SNZ_W'(SNOOZE_S - 1));
`else
  logic unused_snooze;
  assign unused_snooze = snooze & (SNOOZE_S > 0);
`endif

  assign hp_cur       = hp_of(note_q);
  // Last cycle of the final allowed second of ringing.
  assign ring_timeout = (cyc_q == SEC_W'(SEC_CYC - 1)) &&
                        (sec_q == TMO_W'(MAX_PLAY_S - 1));

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      speaker_q <= 1'b0;
      active_q  <= 1'b0;
      note_q    <= '0;
      done_q    <= 1'b0;
      tone_q    <= '0;
      slot_q    <= '0;
      cyc_q     <= '0;
      sec_q     <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cyc_q <= '0;
      snz_sec_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      speaker_q <= speaker_d;
      active_q  <= active_d;
      note_q    <= note_d;
      done_q    <= done_d;
      tone_q    <= tone_d;
      slot_q    <= slot_d;
      cyc_q     <= cyc_d;
      sec_q     <= sec_d;
`ifdef ALARM_SNOOZE_EN
      snz_cyc_q <= snz_cyc_d;
      snz_sec_q <= snz_sec_d;
`endif
    end
  end

  // Next-state logic; event priority is stop > play-fall > snooze > timeout > advance.
  always_comb begin
    state_d   = state_q;
    speaker_d = speaker_q;
    note_d    = note_q;
    done_d    = 1'b0;
    tone_d    = tone_q;
    slot_d    = slot_q;
    cyc_d     = cyc_q;
    sec_d     = sec_q;
`ifdef ALARM_SNOOZE_EN
    snz_cyc_d = snz_cyc_q;
    snz_sec_d = snz_sec_q;
`endif
    case (state_q)
      IDLE: begin
        speaker_d = 1'b0;
        note_d    = '0;
        if (play) begin
          state_d = RING;
          tone_d  = '0;
          slot_d  = '0;
          cyc_d   = '0;
          sec_d   = '0;
        end
      end
      RING, GAP: begin
        if (stop) begin
          state_d   = HOLD;
          speaker_d = 1'b0;
          note_d    = '0;
          done_d    = 1'b1;
        end else if (!play) begin
          state_d   = IDLE;
          speaker_d = 1'b0;
          note_d    = '0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_d   = SNOOZE;
          speaker_d = 1'b0;
          note_d    = '0;
          cyc_d     = '0;
          sec_d     = '0;
          snz_cyc_d = '0;
          snz_sec_d = '0;
`endif
        end else if (ring_timeout) begin
          state_d   = HOLD;
          speaker_d = 1'b0;
          note_d    = '0;
          done_d    = 1'b1;
        end else begin
          if (cyc_q == SEC_W'(SEC_CYC - 1)) begin
            cyc_d = '0;
            sec_d = sec_q + TMO_W'(1);
          end else begin
            cyc_d = cyc_q + SEC_W'(1);
          end
          if (state_q == RING) begin
            if (slot_q == SLOT_W'(RING_CYC - 1)) begin
              state_d   = GAP;
              slot_d    = '0;
              tone_d    = '0;
              speaker_d = 1'b0;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
              if (hp_cur == '0) begin
                tone_d    = '0;
                speaker_d = 1'b0;
              end else if (tone_q == hp_cur - TONE_W'(1)) begin
                tone_d    = '0;
                speaker_d = ~speaker_q;
              end else begin
                tone_d = tone_q + TONE_W'(1);
              end
            end
          end else begin
            if (slot_q == SLOT_W'(GAP_CYC - 1)) begin
              state_d = RING;
              slot_d  = '0;
              tone_d  = '0;
              note_d  = note_q + 3'd1;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
      end
      HOLD: begin
        speaker_d = 1'b0;
        note_d    = '0;
        if (!play) state_d = IDLE;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        speaker_d = 1'b0;
        note_d    = '0;
        if (stop) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else if (!play) begin
          state_d = IDLE;
        end else if (snooze_over) begin
          state_d = RING;
          tone_d  = '0;
          slot_d  = '0;
          cyc_d   = '0;
          sec_d   = '0;
        end else if (snz_cyc_q == SEC_W'(SEC_CYC - 1)) begin
          snz_cyc_d = '0;
          snz_sec_d = snz_sec_q + SNZ_W'(1);
        end else begin
          snz_cyc_d = snz_cyc_q + SEC_W'(1);
        end
      end
`endif
      default: begin
        state_d   = IDLE;
        speaker_d = 1'b0;
        note_d    = '0;
      end
    endcase
    active_d = (state_d == RING) || (state_d == GAP);
  end

  assign speaker   = speaker_q;
  assign active    = active_q;
  assign note_idx  = note_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alarm_tone_player.sv
// Bench for alarm_tone_player at CLK_HZ=16000, NOTE_MS=8, MAX_PLAY_S=2,
// SNOOZE_S=1. Each driven cycle pushes its expected post-edge outputs to a
// queue; a negedge monitor pops and compares them. The snooze section follows
// ALARM_SNOOZE_EN.
module tb_alarm_tone_player;

  localparam int W = 10;  // {care, state[2:0], done, active, speaker, note[2:0]}
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RING   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_SNOOZE = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst, play, stop, snooze;
  logic speaker, active, done;
  logic [2:0] note_idx, state_dbg;

  always #5 clk = ~clk;

  alarm_tone_player #(
    .CLK_HZ(16000), .NOTE_MS(8), .MAX_PLAY_S(2), .SNOOZE_S(1)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .snooze(snooze),
    .speaker(speaker), .active(active), .note_idx(note_idx), .done(done),
    .state_dbg(state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int checks = 0;
  int errors = 0;
  int hp_tab [8] = '{15, 12, 10, 7, 10, 12, 15, 0};

  logic [W-1:0] mon_e;
  string        mon_t;
  logic [W-2:0] mon_got;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_t   = tag_q.pop_front();
      mon_got = {state_dbg, done, active, speaker, note_idx};
      if (mon_e[W-1]) begin
        checks++;
        if (mon_got !== mon_e[W-2:0]) begin
          errors++;
          $display("FAIL %s: got st=%0d done=%b act=%b spk=%b note=%0d, expected st=%0d done=%b act=%b spk=%b note=%0d",
                   mon_t, mon_got[8:6], mon_got[5], mon_got[4], mon_got[3], mon_got[2:0],
                   mon_e[8:6], mon_e[5], mon_e[4], mon_e[3], mon_e[2:0]);
        end
      end
    end
  end

  function automatic logic [W-2:0] pack(input logic [2:0] st, input logic dn,
                                        input logic act, input logic spk,
                                        input logic [2:0] note);
    return {st, dn, act, spk, note};
  endfunction

  // Expected outputs k edges after the edge that saw play rise (k=0 is that edge).
  function automatic logic [W-2:0] ring_model(input int k);
    int s, nt;
    logic spk;
    s   = k % 128;
    nt  = (k / 128) % 8;
    spk = 1'b0;
    if (s < 112 && hp_tab[nt] != 0) spk = ((s / hp_tab[nt]) % 2) == 1;
    return pack((s < 112) ? S_RING : S_GAP, 1'b0, 1'b1, spk, 3'(nt));
  endfunction

  // driver
  task automatic drive_cycle(input string tag, input logic p, input logic s,
                             input logic z, input logic care, input logic [W-2:0] e);
    play   = p;
    stop   = s;
    snooze = z;
    exp_q.push_back({care, e});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       play, stop, snooze;
    int         n;
    logic [2:0] st;
    logic       dn, act, spk;
    logic [2:0] note;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input string nm, input logic p, input logic s,
                              input logic z, input int n, input logic [2:0] st,
                              input logic dn, input logic act, input logic spk,
                              input logic [2:0] note);
    vec_t v;
    v.name = nm; v.play = p; v.stop = s; v.snooze = z; v.n = n;
    v.st = st; v.dn = dn; v.act = act; v.spk = spk; v.note = note;
    vecs.push_back(v);
  endfunction

  initial begin
    // Table: inputs held for n cycles, outputs compared after the last edge.
    add("hold_no_restart", 1, 0, 0,   5, S_HOLD, 0, 0, 0, 0);
    add("play_drop_idle",  0, 0, 0,   1, S_IDLE, 0, 0, 0, 0);
    add("idle_wait",       0, 0, 0,   3, S_IDLE, 0, 0, 0, 0);
    add("restart_note0",   1, 0, 0,   1, S_RING, 0, 1, 0, 0);
    add("first_toggle",    1, 0, 0,  15, S_RING, 0, 1, 1, 0);
    add("second_toggle",   1, 0, 0,  15, S_RING, 0, 1, 0, 0);
    add("gap_enter",       1, 0, 0,  82, S_GAP,  0, 1, 0, 0);
    add("note1_start",     1, 0, 0,  16, S_RING, 0, 1, 0, 1);
    add("note1_toggle",    1, 0, 0,  12, S_RING, 0, 1, 1, 1);
    add("note3_mid",       1, 0, 0, 266, S_RING, 0, 1, 1, 3);
    add("stop_note3",      1, 1, 0,   1, S_HOLD, 1, 0, 0, 0);
    add("done_once",       1, 0, 0,   1, S_HOLD, 0, 0, 0, 0);
    add("no_retrigger",    1, 0, 0,  20, S_HOLD, 0, 0, 0, 0);
    add("release",         0, 0, 0,   1, S_IDLE, 0, 0, 0, 0);
    add("ring_again",      1, 0, 0,   1, S_RING, 0, 1, 0, 0);
    add("into_gap",        1, 0, 0, 112, S_GAP,  0, 1, 0, 0);
    add("gap_hold",        1, 0, 0,   3, S_GAP,  0, 1, 0, 0);
    add("gap_play_fall",   0, 0, 0,   1, S_IDLE, 0, 0, 0, 0);
    add("idle_after_fall", 0, 0, 0,   2, S_IDLE, 0, 0, 0, 0);
    add("ring_third",      1, 0, 0,   1, S_RING, 0, 1, 0, 0);
    add("ring_k50",        1, 0, 0,  50, S_RING, 0, 1, 1, 0);
    add("stop_and_fall",   0, 1, 0,   1, S_HOLD, 1, 0, 0, 0);
    add("hold_to_idle",    0, 0, 0,   1, S_IDLE, 0, 0, 0, 0);
    add("snz_ring",        1, 0, 0,   1, S_RING, 0, 1, 0, 0);
    add("snz_k45",         1, 0, 0,  45, S_RING, 0, 1, 1, 0);
`ifdef ALARM_SNOOZE_EN
    add("snooze_enter",    1, 0, 1,     1, S_SNOOZE, 0, 0, 0, 0);
    add("snooze_wait",     1, 0, 0, 15999, S_SNOOZE, 0, 0, 0, 0);
    add("snooze_resume",   1, 0, 0,     1, S_RING,   0, 1, 0, 0);
    add("resume_toggle",   1, 0, 0,    15, S_RING,   0, 1, 1, 0);
    add("snooze_again",    1, 0, 1,     1, S_SNOOZE, 0, 0, 0, 0);
    add("snooze_idle",     1, 0, 0,    10, S_SNOOZE, 0, 0, 0, 0);
    add("stop_in_snooze",  1, 1, 0,     1, S_HOLD,   1, 0, 0, 0);
`else
    add("snooze_ignored",  1, 0, 1,     1, S_RING, 0, 1, 1, 0);
    add("no_snooze_wait",  1, 0, 0, 15999, S_RING, 0, 1, 1, 5);
    add("still_ringing",   1, 0, 0,     1, S_RING, 0, 1, 1, 5);
    add("ring_on",         1, 0, 0,    15, S_RING, 0, 1, 1, 5);
    add("snooze_ignored2", 1, 0, 1,     1, S_RING, 0, 1, 1, 5);
    add("ring_on2",        1, 0, 0,    10, S_RING, 0, 1, 0, 5);
    add("stop_ring",       1, 1, 0,     1, S_HOLD, 1, 0, 0, 0);
`endif
    add("final_hold",      1, 0, 0,   1, S_HOLD, 0, 0, 0, 0);
    add("final_idle",      0, 0, 0,   1, S_IDLE, 0, 0, 0, 0);

    // Reset and idle.
    rst = 1'b1; play = 1'b0; stop = 1'b0; snooze = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle("reset", 0, 0, 0, 1, pack(S_IDLE, 0, 0, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 2; i++) drive_cycle("idle", 0, 0, 0, 1, pack(S_IDLE, 0, 0, 0, 0));

    // Continuous play checked every cycle up to the ring timeout.
    for (int k = 0; k < 32000; k++) drive_cycle("ring_model", 1, 0, 0, 1, ring_model(k));
    drive_cycle("timeout_done", 1, 0, 0, 1, pack(S_HOLD, 1, 0, 0, 0));
    drive_cycle("timeout_hold", 1, 0, 0, 1, pack(S_HOLD, 0, 0, 0, 0));

    // Table-driven corner cases.
    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        drive_cycle(vecs[i].name, vecs[i].play, vecs[i].stop, vecs[i].snooze,
                    c == vecs[i].n - 1,
                    pack(vecs[i].st, vecs[i].dn, vecs[i].act, vecs[i].spk, vecs[i].note));
      end
    end

    // Final report.
    play = 1'b0; stop = 1'b0; snooze = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
